// File: rtl/vn_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : vn_accumulator_if
// Purpose  : Beat-in / result-out handshake bundle for the variable-node accumulator.
// Revision : 1.0
// ============================================================================
interface vn_accumulator_if #(
    parameter int W = 6
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_sum;
    logic         hard_bit;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_sum,
        input  hard_bit,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_sum,
        output hard_bit,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/vn_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : vn_accumulator
// Purpose  : Sums channel LLR plus DEG check messages, outputs clamped sum and hard bit.
// Revision : 1.0
// ============================================================================
module vn_accumulator #(
    parameter int W     = 6,
    parameter int DEG   = 3,
    parameter int ACC_W = W + $clog2(DEG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    vn_accumulator_if.slave   bus
);
    localparam int CNT_W = $clog2(DEG + 2);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ACCUM = 2'd1;
    localparam logic [1:0] C_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0]        C_CNT_LAST = CNT_W'(DEG);
    localparam logic [CNT_W-1:0]        C_CNT_ONE  = CNT_W'(1);
    localparam logic signed [ACC_W-1:0] C_ACC_MAX  = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] C_ACC_MIN  = -C_ACC_MAX;
    localparam logic signed [W-1:0]     C_OUT_MAX  = W'((2 ** (W - 1)) - 1);
    localparam logic signed [W-1:0]     C_OUT_MIN  = -C_OUT_MAX;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_out_sum;
    logic             r_hard_bit;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_op_a;
    logic [ACC_W-1:0] w_op_b;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_carry;
    logic [W-1:0]     w_sat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = C_ACCUM;
                end
            end
            C_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_nxt = C_HOLD;
                end
            end
            C_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = C_IDLE;
                end
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode; in_ready is forced low while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            C_IDLE:  w_in_ready  = rst_n;
            C_ACCUM: w_in_ready  = rst_n;
            C_HOLD:  w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_state == C_ACCUM) && (r_cnt == C_CNT_LAST);

    // ------------------------------------------------------------------
    // Ripple-carry adder: the first beat adds onto zero
    // ------------------------------------------------------------------
    assign w_op_a     = (r_state == C_IDLE) ? '0 : r_acc;
    assign w_op_b     = {{(ACC_W - W){bus.in_data[W-1]}}, bus.in_data};
    assign w_carry[0] = 1'b0;

    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_rca
        assign w_sum[gi] = w_op_a[gi] ^ w_op_b[gi] ^ w_carry[gi];
        if (gi < ACC_W - 1) begin : g_carry
            assign w_carry[gi+1] = (w_op_a[gi] & w_op_b[gi]) |
                                   (w_carry[gi] & (w_op_a[gi] ^ w_op_b[gi]));
        end
    end

    // Symmetric clamp keeps the most negative code off the output
    always_comb begin
        w_sat = w_sum[W-1:0];
        if ($signed(w_sum) > C_ACC_MAX) begin
            w_sat = C_OUT_MAX;
        end else if ($signed(w_sum) < C_ACC_MIN) begin
            w_sat = C_OUT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator, beat counter and registered result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_sum  <= '0;
            r_hard_bit <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= (r_state == C_IDLE) ? C_CNT_ONE : (r_cnt + C_CNT_ONE);
            if (w_last) begin
                r_out_sum  <= w_sat;
                r_hard_bit <= w_sum[ACC_W-1];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.hard_bit  = r_hard_bit;

endmodule
`default_nettype wire
